// File: rtl/alarm_ctrl.sv
// alarm_ctrl - alarm sequencing controller for the Lab3 alarm clock.
//
// Compares the running time digits against the alarm digits and sequences
// DISARMED / ARMED / RINGING / SNOOZE from UART command characters and the
// one-second strobe.
//
// Build option:
//   ALARM_SNOOZE_EN  when defined, the SNOOZE state, the 'S'/'s' command and
//                    o_snoozing are present; otherwise o_snoozing is tied low.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   i_oneSecStrb             one-cycle strobe, once per second
//   i_oneSecPluse            1 Hz square wave used to flash the digits
//   rx_data_rdy, rx_data     UART character and its one-cycle qualifier
//   di_M/S tens/ones         current time, BCD
//   di_AM/AS tens/ones       alarm time, BCD
//   o_armed                  ARMED, RINGING or SNOOZE
//   o_ringing, o_snoozing    state is RINGING / SNOOZE
//   o_blank                  blank the four 7-segment digits this cycle
//   o_status                 ASCII status 'D', 'A', 'R' or 'Z'
module alarm_ctrl #(
   parameter int unsigned RING_SECS   = 30,
   parameter int unsigned SNOOZE_SECS = 60,
   parameter int unsigned CNT_W       = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_oneSecStrb,
   input  logic       i_oneSecPluse,
   input  logic       rx_data_rdy,
   input  logic [7:0] rx_data,
   input  logic [3:0] di_Mtens,
   input  logic [3:0] di_Mones,
   input  logic [3:0] di_Stens,
   input  logic [3:0] di_Sones,
   input  logic [3:0] di_AMtens,
   input  logic [3:0] di_AMones,
   input  logic [3:0] di_AStens,
   input  logic [3:0] di_ASones,
   output logic       o_armed,
   output logic       o_ringing,
   output logic       o_snoozing,
   output logic       o_blank,
   output logic [7:0] o_status
);

   typedef enum logic [1:0] {
      ST_DISARMED = 2'd0,
      ST_ARMED    = 2'd1,
      ST_RINGING  = 2'd2
`ifdef ALARM_SNOOZE_EN
      , ST_SNOOZE = 2'd3
`endif
   } state_t;

   localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_SECS - 1);
`ifdef ALARM_SNOOZE_EN
   localparam logic [CNT_W-1:0] SNZ_LAST  = CNT_W'(SNOOZE_SECS - 1);
`endif

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             match_q;
   logic             match, trig;
   logic             cmd_arm, cmd_disarm, cmd_stop;
   logic [7:0]       status_d;

   assign match = ({di_Mtens, di_Mones, di_Stens, di_Sones} ==
                   {di_AMtens, di_AMones, di_AStens, di_ASones});
   // Only the rising edge of match rings; match_q resets to 1 so a reset
   // while time == alarm does not produce a spurious edge.
   assign trig  = match & ~match_q;

   assign cmd_arm    = rx_data_rdy & ((rx_data == 8'h41) | (rx_data == 8'h61));
   assign cmd_disarm = rx_data_rdy & ((rx_data == 8'h44) | (rx_data == 8'h64));
   assign cmd_stop   = rx_data_rdy & (rx_data == 8'h1b);
`ifdef ALARM_SNOOZE_EN
   logic cmd_snooze;
   assign cmd_snooze = rx_data_rdy & ((rx_data == 8'h53) | (rx_data == 8'h73));
`endif

   // Priority: DISARM/STOP > SNOOZE > timeout > trig. A strobe only counts
   // when no effective command is taken in the same cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_DISARMED: begin
            if (cmd_arm) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (cmd_disarm) begin
               state_d = ST_DISARMED;
            end else if (trig) begin
               state_d = ST_RINGING;
               cnt_d   = '0;
            end
         end
         ST_RINGING: begin
            if (cmd_disarm) begin
               state_d = ST_DISARMED;
            end else if (cmd_stop) begin
               state_d = ST_ARMED;
`ifdef ALARM_SNOOZE_EN
            end else if (cmd_snooze) begin
               state_d = ST_SNOOZE;
               cnt_d   = '0;
`endif
            end else if (i_oneSecStrb) begin
               if (cnt_q >= RING_LAST) state_d = ST_ARMED;
               else                    cnt_d   = cnt_q + 1'b1;
            end
         end
`ifdef ALARM_SNOOZE_EN
         ST_SNOOZE: begin
            if (cmd_disarm || cmd_stop) begin
               state_d = ST_DISARMED;
            end else if (i_oneSecStrb) begin
               if (cnt_q >= SNZ_LAST) begin
                  state_d = ST_RINGING;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
`endif
         default: begin
            state_d = ST_DISARMED;
         end
      endcase
   end

   always_comb begin
      status_d = 8'h44;
      unique case (state_d)
         ST_ARMED:   status_d = 8'h41;
         ST_RINGING: status_d = 8'h52;
`ifdef ALARM_SNOOZE_EN
         ST_SNOOZE:  status_d = 8'h5a;
`endif
         default:    status_d = 8'h44;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_DISARMED;
         cnt_q     <= '0;
         match_q   <= 1'b1;
         o_armed   <= 1'b0;
         o_ringing <= 1'b0;
         o_status  <= 8'h44;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         match_q   <= match;
         o_armed   <= (state_d != ST_DISARMED);
         o_ringing <= (state_d == ST_RINGING);
         o_status  <= status_d;
      end
   end

`ifdef ALARM_SNOOZE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) o_snoozing <= 1'b0;
      else     o_snoozing <= (state_d == ST_SNOOZE);
   end
`else
   assign o_snoozing = 1'b0;
`endif

   assign o_blank = o_ringing & ~i_oneSecPluse;

endmodule
